// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - MEM-stage data memory with fixed access latency and pipeline stall
// Byte/halfword loads and stores are enabled by defining DMEM_SUBWORD_EN.
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = ($clog2(LATENCY + 1) > 3) ? $clog2(LATENCY + 1) : 3;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rd;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_store;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic          w_misal;
  logic [31:0]   w_load_val;
  logic [31:0]   w_store_val;
  logic          w_go;
  logic          w_complete;
  logic          w_unused;

  // Reset gates the request so nothing stalls, flags or writes while start_i is low.
  assign w_req   = start_i & (MemRead_i | MemWrite_i);
  assign w_store = MemWrite_i;
  assign w_idx   = addr_i[AW+1:2];
  assign w_word  = r_mem[w_idx];

`ifdef DMEM_SUBWORD_EN
  logic        w_byte;
  logic        w_half;
  logic [4:0]  w_sh;
  logic [31:0] w_lane;

  assign w_sh     = {addr_i[1:0], 3'b000};
  assign w_lane   = w_word >> w_sh;
  assign w_unused = ^addr_i[31:AW+2];

  always_comb begin
    w_byte      = 1'b0;
    w_half      = 1'b0;
    w_load_val  = w_word;
    w_store_val = WriteData_i;
    if (w_store) begin
      w_byte = (funct3_i == 3'b000);
      w_half = (funct3_i == 3'b001);
    end else begin
      w_byte = (funct3_i == 3'b000) || (funct3_i == 3'b100);
      w_half = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    end
    if (w_byte) begin
      w_load_val  = funct3_i[2] ? {24'h0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      w_store_val = (w_word & ~(32'h0000_00FF << w_sh)) | ({24'h0, WriteData_i[7:0]} << w_sh);
    end else if (w_half) begin
      w_load_val  = funct3_i[2] ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      w_store_val = (w_word & ~(32'h0000_FFFF << w_sh)) | ({16'h0, WriteData_i[15:0]} << w_sh);
    end
  end

  assign w_misal = (w_half & addr_i[0]) | (~w_half & ~w_byte & (|addr_i[1:0]));
`else
  assign w_misal     = |addr_i[1:0];
  assign w_load_val  = w_word;
  assign w_store_val = WriteData_i;
  assign w_unused    = ^{addr_i[31:AW+2], funct3_i};
`endif

  assign w_go       = (r_state == IDLE) & w_req & ~w_misal;
  assign w_complete = (LATENCY == 1) ? w_go : ((r_state == BUSY) && (r_cnt == LAST));

  assign stall_o    = (w_go & (LATENCY > 1)) | ((r_state == BUSY) && (r_cnt != LAST));
  assign err_o      = (r_state == IDLE) & w_req & w_misal;
  assign ReadData_o = (w_complete & ~w_store) ? w_load_val : r_rd;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
    end else begin
      if (w_complete && !w_store) r_rd <= w_load_val;
      case (r_state)
        IDLE: begin
          if (w_go && (LATENCY > 1)) begin
            r_state <= BUSY;
            r_cnt   <= CW'(1);
          end
        end
        BUSY: begin
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // The array is deliberately outside the reset domain so its contents survive start_i low.
  always_ff @(posedge clk_i) begin
    if (w_complete && w_store) r_mem[w_idx] <= w_store_val;
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl
// Instance 0 uses LATENCY=2, instance 1 uses LATENCY=4; both DEPTH_WORDS=256.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        start [2];
  logic        mrd   [2];
  logic        mwr   [2];
  logic [2:0]  f3    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        err   [2];

  data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
    .clk_i(clk), .start_i(start[0]), .MemRead_i(mrd[0]), .MemWrite_i(mwr[0]),
    .funct3_i(f3[0]), .addr_i(addr[0]), .WriteData_i(wdata[0]),
    .ReadData_o(rdata[0]), .stall_o(stall[0]), .err_o(err[0])
  );

  data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .start_i(start[1]), .MemRead_i(mrd[1]), .MemWrite_i(mwr[1]),
    .funct3_i(f3[1]), .addr_i(addr[1]), .WriteData_i(wdata[1]),
    .ReadData_o(rdata[1]), .stall_o(stall[1]), .err_o(err[1])
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  mb      [2][1024];
  bit          kn      [2][1024];
  logic [31:0] last_rd [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Byte-addressed model: memory is 1024 bytes, addresses wrap modulo 1024.
  task automatic access(input int d, input logic we, input logic re, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic got_err, output logic [31:0] got_rd);
    int          sz;
    int          n;
    int          lat;
    int          base;
    bit          sgn;
    bit          mis;
    bit          known;
    logic [31:0] mv;
    lat   = (d == 0) ? 2 : 4;
    known = 1'b0;
    got_rd = 32'h0;
    @(negedge clk);
    mwr[d] = we; mrd[d] = re; f3[d] = fn; addr[d] = a; wdata[d] = wd;
`ifdef DMEM_SUBWORD_EN
    if (we) sz = (fn == 3'd0) ? 1 : (fn == 3'd1) ? 2 : 4;
    else    sz = (fn == 3'd0 || fn == 3'd4) ? 1 : (fn == 3'd1 || fn == 3'd5) ? 2 : 4;
    sgn = !we && (fn == 3'd0 || fn == 3'd1);
`else
    sz  = 4;
    sgn = 1'b0;
`endif
    mis  = (int'(a[1:0]) % sz) != 0;
    base = int'(a[9:0]);
    #1;
    got_err = err[d];
    chk("err_flag", 32'(err[d]), 32'(mis));
    if (mis) begin
      chk("err_no_stall", 32'(stall[d]), 32'h0);
      chk("err_rd_hold", rdata[d], last_rd[d]);
    end else begin
      n = 0;
      while (stall[d] && n < 20) begin
        chk("busy_no_err", 32'(err[d]), 32'h0);
        n++;
        @(posedge clk); #1;
      end
      chk("stall_len", 32'(n), 32'(lat - 1));
      if (!we) begin
        mv    = 32'h0;
        known = 1'b1;
        for (int i = 0; i < sz; i++) begin
          mv    = mv | (32'(mb[d][base + i]) << (8 * i));
          known = known & kn[d][base + i];
        end
        if (sgn && sz == 1) mv = {{24{mv[7]}}, mv[7:0]};
        if (sgn && sz == 2) mv = {{16{mv[15]}}, mv[15:0]};
        got_rd = rdata[d];
        if (known) begin
          chk("load_data", rdata[d], mv);
          last_rd[d] = mv;
        end
      end else begin
        for (int i = 0; i < sz; i++) begin
          mb[d][base + i] = wd[8 * i +: 8];
          kn[d][base + i] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    if (!we && !mis && known) chk("rd_hold", rdata[d], last_rd[d]);
    mwr[d] = 1'b0; mrd[d] = 1'b0;
  endtask

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic        ge;
    logic [31:0] gr;
    logic [31:0] a;

    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; mrd[d] = 1'b0; mwr[d] = 1'b0; f3[d] = 3'b010;
      addr[d] = 32'h0; wdata[d] = 32'h0; last_rd[d] = 32'h0;
      for (int i = 0; i < 1024; i++) kn[d][i] = 1'b0;
    end
    mrd[0]  = 1'b1;
    addr[0] = 32'h10;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdata", rdata[0], 32'h0);
      chk("rst_stall", 32'(stall[0]), 32'h0);
      chk("rst_err", 32'(err[0]), 32'h0);
    end
    mrd[0] = 1'b0;
    @(negedge clk);
    start[0] = 1'b1; start[1] = 1'b1;

    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h13,  32'h0,        1'b1, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h0,   32'h0,        1'b0, 1'b1, 32'hA5A5A5A5});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h12,  32'h11223344, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
`ifdef DMEM_SUBWORD_EN
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h30,  32'h000000F0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h31,  32'h00000080, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 32'h31,  32'h0,        1'b0, 1'b1, 32'hFFFFFF80});
    tbl.push_back('{1'b0, 1'b1, 3'b100, 32'h31,  32'h0,        1'b0, 1'b1, 32'h00000080});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h30,  32'h0,        1'b0, 1'b1, 32'h000080F0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 32'h31,  32'h0,        1'b1, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h32,  32'h1234BEEF, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 32'h32,  32'h0,        1'b0, 1'b1, 32'hFFFFBEEF});
    tbl.push_back('{1'b0, 1'b1, 3'b101, 32'h32,  32'h0,        1'b0, 1'b1, 32'h0000BEEF});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h30,  32'h0,        1'b0, 1'b1, 32'hBEEF80F0});
`endif
    foreach (tbl[i]) begin
      v = tbl[i];
      access(0, v.we, v.re, v.fn, v.a, v.wd, ge, gr);
      chk("tbl_err", 32'(ge), 32'(v.exp_err));
      if (v.chk_rd) chk("tbl_rd", gr, v.exp_rd);
    end

    // LATENCY=4: preload, then abort an in-flight store at cnt=2 with reset.
    access(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h11111111, ge, gr);
    access(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, ge, gr);
    chk("l4_preload", gr, 32'h11111111);
    @(negedge clk);
    mwr[1] = 1'b1; mrd[1] = 1'b0; f3[1] = 3'b010; addr[1] = 32'h20; wdata[1] = 32'h12345678;
    #1 chk("l4_stall_idle", 32'(stall[1]), 32'h1);
    @(posedge clk); #1 chk("l4_stall_cnt1", 32'(stall[1]), 32'h1);
    @(posedge clk); #1 chk("l4_stall_cnt2", 32'(stall[1]), 32'h1);
    start[1] = 1'b0;
    #1;
    chk("l4_abort_stall", 32'(stall[1]), 32'h0);
    chk("l4_abort_rd", rdata[1], 32'h0);
    chk("l4_abort_err", 32'(err[1]), 32'h0);
    mwr[1] = 1'b0;
    last_rd[1] = 32'h0;
    @(negedge clk);
    start[1] = 1'b1;
    access(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, ge, gr);
    chk("l4_store_lost", gr, 32'h11111111);

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        access(d, 1'b1, 1'b0, 3'b010, 32'(w * 4), $urandom, ge, gr);
    for (int k = 0; k < 240; k++) begin
      int          d;
      logic        we;
      logic        re;
      logic [2:0]  fn;
      d  = (k < 200) ? 0 : 1;
      we = 1'($urandom_range(0, 1));
      re = we ? 1'($urandom_range(0, 1)) : 1'b1;
      fn = 3'($urandom_range(0, 7));
      a  = $urandom & 32'hFFFF_FC3F;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      access(d, we, re, fn, a, $urandom, ge, gr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Data-memory access unit for the MEM stage of the pipelined CPU. It performs loads and stores addressed by the EX/MEM ALU result against an internal word-organised memory with a fixed multi-cycle access latency. It stalls the pipeline until each access completes, and drives `ReadData_o` straight into the MEM/WB register's `ReadData_i` in the cycle the load completes.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two, at least 4.
- `LATENCY`, default 2: cycles one access occupies the unit; must be at least 1.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `start_i`  in  1  reset, asynchronous, active-low.
- `MemRead_i`  in  1  load request from EX/MEM.
- `MemWrite_i`  in  1  store request from EX/MEM.
- `funct3_i`  in  3  access size and sign; used only with `DMEM_SUBWORD_EN`.
- `addr_i`  in  32  byte address (ALU result).
- `WriteData_i`  in  32  store data.
- `ReadData_o`  out  32  load result, fed to MEM/WB.
- `stall_o`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB takes a bubble.
- `err_o`  out  1  misaligned-access flag, combinational.

## Operation
- FSM states: IDLE and BUSY. A 3-bit-or-wider counter `cnt` counts cycles spent in BUSY.
- Request: `MemRead_i | MemWrite_i`. When both are high, the request is a store.
- Word index: `addr_i[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so out-of-range addresses wrap.
- Misaligned request:
  - Condition: word access with `addr_i[1:0]!=0`, or halfword access with `addr_i[0]!=0`.
  - Response: `err_o=1` in that cycle, no access, no stall, FSM stays in IDLE, memory and `ReadData_o` unchanged.
- IDLE with an aligned request:
  - If `LATENCY==1`: the access completes this cycle and the FSM stays in IDLE.
  - Otherwise: go to BUSY with `cnt=1`.
- BUSY:
  - If `cnt==LATENCY-1`: complete and return to IDLE.
  - Otherwise: `cnt<=cnt+1`.
- Completion actions:
  - Store: write the memory at the completing edge.
  - Load: update internal register `rd_q` with the load value at that edge.
- `ReadData_o`:
  - In the completing cycle of a load: the combinational load value.
  - All other cycles: `rd_q`.
- Upstream must hold all request inputs stable while `stall_o=1`. The unit samples the inputs every cycle and does not latch them.
- Memory array is not reset, and its contents survive `start_i` low.
- Reset values: FSM IDLE, `cnt=0`, `rd_q=0`, so `ReadData_o=0`, `stall_o=0`, `err_o=0`.
- Reset mid-access: abort immediately. An in-flight store is discarded and an in-flight load leaves `rd_q=0`.

## Timing
- `stall_o` is combinational:
  - High in IDLE with an aligned request and `LATENCY>1`.
  - High in BUSY with `cnt!=LATENCY-1`.
  - Low otherwise.
- Each aligned access keeps `stall_o` high for exactly `LATENCY-1` cycles. The access completes in the following cycle, with `stall_o=0`.
- Load data is valid in the completing cycle and is captured by MEM/WB at that cycle's closing edge.
- Back-to-back accesses: a new request presented in the cycle after completion starts a fresh access from IDLE, with no dead cycle.
- `err_o` and `stall_o` are never high together.

## Configuration
- `DMEM_SUBWORD_EN` defined: `funct3_i` selects the access.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Byte lane is selected by `addr_i[1:0]`. Byte and halfword stores perform a read-modify-write of only the addressed lanes.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Any other `funct3_i` is treated as a word access.
- `DMEM_SUBWORD_EN` undefined: `funct3_i` is ignored. Every access is a full word, and only `addr_i[1:0]!=0` is misaligned.

## Test plan
- Reset: hold `start_i=0` for 3 cycles while `MemRead_i=1` -> `ReadData_o=0`, `stall_o=0`, `err_o=0` throughout.
- Store then load, `LATENCY=2`: SW 0xDEADBEEF to 0x10, then LW 0x10 -> each access has `stall_o=1` for 1 cycle; in the load's completing cycle `ReadData_o=0xDEADBEEF`.
- Misaligned: LW at 0x13 -> `err_o=1` for 1 cycle, `stall_o=0`, `ReadData_o` unchanged, word 0x10 still 0xDEADBEEF.
- Reset mid-access, `LATENCY=4`: SW 0x12345678 to 0x20, drop `start_i` while `cnt=2`, then LW 0x20 -> the preloaded old value is returned and the store is lost.
- Subword, with `DMEM_SUBWORD_EN`: SW 0x000000F0 to 0x30, SB 0x80 to 0x31, LB 0x31 -> `0xFFFFFF80`; LBU 0x31 -> `0x00000080`; LW 0x30 -> `0x000080F0`.
- Wrap and simultaneous request: `DEPTH_WORDS=256`, SW 0xA5A5A5A5 to 0x400 with `MemRead_i=1` also high -> store performed at word 0; LW 0x0 -> `0xA5A5A5A5`.
